// File: rtl/pc_fetch_sequencer.sv
// Fetch-stage sequencer: steers the PC register, issues instruction reads at the current PC
// and holds one fetched instruction for decode, handling stall, redirect and halt.
module pc_fetch_sequencer #(
  parameter int INSTR_BYTES = 4,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [31:0]      pc,
  output logic [31:0]      next_pc,
  output logic             pc_adv,
  output logic             pc_halt,
  output logic             imem_ren,
  output logic [31:0]      imem_addr,
  input  logic             imem_wait,
  input  logic [31:0]      imem_load,
  input  logic             stall,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  input  logic             halt,
  output logic [31:0]      instr,
  output logic [31:0]      instr_pc,
  output logic [31:0]      instr_npc,
  output logic             instr_valid,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);

  localparam logic [31:0] STEP = 32'(INSTR_BYTES);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD, HALTED} state_t;

  state_t state, state_nxt;
  logic   consume;
  logic   capture;
  logic   valid_nxt;
  logic   halt_set;

  assign consume   = instr_valid & ~stall;
  assign instr_npc = instr_pc + STEP;

  always_comb begin
    state_nxt = state;
    next_pc   = pc;
    pc_adv    = 1'b0;
    pc_halt   = 1'b0;
    imem_ren  = 1'b0;
    imem_addr = pc;
    valid_nxt = instr_valid;
    capture   = 1'b0;
    halt_set  = 1'b0;

    case (state)
      BOOT:   state_nxt = FETCH;
      FETCH: begin
        imem_ren = 1'b1;
        if (!imem_wait) begin
          if (!instr_valid || consume) begin
            capture   = 1'b1;
            valid_nxt = 1'b1;
            pc_adv    = 1'b1;
            next_pc   = pc + STEP;
          end else begin
            // Decode still holds the previous instruction: drop this read and retry later.
            state_nxt = HOLD;
          end
        end else if (consume) begin
          valid_nxt = 1'b0;
        end
      end
      HOLD: begin
        if (consume) begin
          valid_nxt = 1'b0;
          state_nxt = FETCH;
        end
      end
      default: pc_halt = 1'b1;
    endcase

    if (redirect && (state == FETCH || state == HOLD)) begin
      capture   = 1'b0;
      pc_adv    = 1'b1;
      next_pc   = redirect_pc;
      valid_nxt = 1'b0;
      state_nxt = FETCH;
    end

    // Halt outranks redirect; BOOT and HALTED ignore it.
    if (halt && (state == FETCH || state == HOLD)) begin
      capture   = 1'b0;
      pc_adv    = 1'b0;
      next_pc   = pc;
      pc_halt   = 1'b1;
      valid_nxt = 1'b0;
      halt_set  = 1'b1;
      state_nxt = HALTED;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= BOOT;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      state       <= state_nxt;
      instr_valid <= valid_nxt;
      if (capture) begin
        instr       <= imem_load;
        instr_pc    <= pc;
        fetch_count <= fetch_count + 1'b1;
      end
      if (halt_set) halted <= 1'b1;
    end
  end

endmodule
